irq_ctrl: RTL and testbench

- Memory-mapped external interrupt controller sitting directly upstream of the CPU datapath.
- Synchronizes up to NUM_IRQ asynchronous device lines, latches them as pending and applies a per-line enable mask.
- Drives the single `irq` input of the datapath.
- The handler reads and acknowledges the block through word accesses issued by the MEMORY stage, in parallel with the data cache.

---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_sync.sv | 29 ++
 rtl/irq_ctrl.sv | 107 ++++++++++
 tb/tb_irq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register offsets and bit positions for the interrupt controller
package irq_pkg;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_ENABLE  = 2'd1;
    localparam logic [1:0] OFF_CLAIM   = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;

    localparam int CLAIM_VALID_BIT = 31;
    localparam int CTRL_GE_BIT     = 0;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - two-flop synchronizer plus prev flop; emits set pulse (edge) or level
module irq_sync #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic set
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= line;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign set = EDGE ? (s2 & ~prev) : s2;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped external interrupt controller feeding the datapath irq input
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int                 NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}},
    parameter logic [31:0]        BASE_ADDR = 32'hFFFF_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    input  logic               writeMem,
    input  logic               readMem,
    input  logic               stop,
    output logic               hit,
    output logic [31:0]        readData,
    output logic               irq
);

    localparam int PAD = 32 - NUM_IRQ;

    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] enable;
    logic               ge;
    logic [NUM_IRQ-1:0] active;
    logic [4:0]         claim_idx;
    logic               claim_valid;
    logic [31:0]        claim_word;
    logic [1:0]         off;
    logic               wr_en;
    logic               claim_fire;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] claim_mask;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync #(.EDGE(EDGE_MASK[i])) u_sync (
            .clk  (clk),
            .rst  (rst),
            .line (irq_lines[i]),
            .set  (set_vec[i])
        );
    end

    assign hit = (address[31:4] == BASE_ADDR[31:4]);
    assign off = address[3:2];

    // Accesses held by a cache stall repeat later, so they must not cause side effects now.
    assign wr_en      = hit & writeMem & ~stop;
    assign claim_fire = hit & readMem & ~writeMem & ~stop & (off == OFF_CLAIM) & claim_valid;

    assign active      = pending & enable;
    assign claim_valid = |active;

    always_comb begin
        claim_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) claim_idx = 5'(i);
        end
    end

    always_comb begin
        claim_word                  = '0;
        claim_word[CLAIM_VALID_BIT] = claim_valid;
        claim_word[4:0]             = claim_idx;
    end

    assign w1c_mask   = (wr_en && off == OFF_PENDING) ? writeData[NUM_IRQ-1:0] : '0;
    assign claim_mask = claim_fire ? (NUM_IRQ'(1) << claim_idx) : '0;

    // Edge bits: a new set beats a same-cycle clear. Level bits simply track the synchronized line.
    assign pending_nxt = (((pending & ~(w1c_mask | claim_mask)) | set_vec) & EDGE_MASK)
                       | (set_vec & ~EDGE_MASK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            enable  <= '0;
            ge      <= 1'b0;
            irq     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            irq     <= ge & claim_valid;
            if (wr_en && off == OFF_ENABLE) enable <= writeData[NUM_IRQ-1:0];
            if (wr_en && off == OFF_CTRL)   ge     <= writeData[CTRL_GE_BIT];
        end
    end

    always_comb begin
        readData = '0;
        if (hit) begin
            case (off)
                OFF_PENDING: readData = {{PAD{1'b0}}, pending};
                OFF_ENABLE:  readData = {{PAD{1'b0}}, enable};
                OFF_CLAIM:   readData = claim_word;
                default:     readData = {31'b0, ge};
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, address[1:0], writeData[31:NUM_IRQ]};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl with a behavioural reference model
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [7:0]  EMASK = 8'hFE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  irq_lines = 8'h00;
    logic [31:0] address = 32'h0;
    logic [31:0] writeData = 32'h0;
    logic        writeMem = 1'b0;
    logic        readMem = 1'b0;
    logic        stop = 1'b0;
    logic        hit;
    logic [31:0] readData;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(8), .EDGE_MASK(EMASK), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_lines (irq_lines),
        .address   (address),
        .writeData (writeData),
        .writeMem  (writeMem),
        .readMem   (readMem),
        .stop      (stop),
        .hit       (hit),
        .readData  (readData),
        .irq       (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a line is seen by the block two edges after it is sampled.
    logic [7:0] m_pend, m_en, h0, h1, h2, m_act, m_clr, m_set;
    logic       m_ge, m_irq;
    int         m_first;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 0; m_en = 0; m_ge = 0; m_irq = 0; h0 = 0; h1 = 0; h2 = 0;
        end else begin
            m_act   = m_pend & m_en;
            m_first = lowest(m_act);
            m_clr   = 0;
            if (address[31:4] == BASE[31:4] && !stop) begin
                if (writeMem) begin
                    if (address[3:2] == 2'd0) m_clr = writeData[7:0];
                end else if (readMem && address[3:2] == 2'd2 && m_first >= 0) begin
                    m_clr[m_first] = 1'b1;
                end
            end
            m_set = h1 & ~h2;
            m_irq = m_ge && (m_act != 0);
            for (int i = 0; i < 8; i++)
                m_pend[i] = EMASK[i] ? (m_set[i] | (m_pend[i] & ~m_clr[i])) : h1[i];
            if (address[31:4] == BASE[31:4] && !stop && writeMem) begin
                if (address[3:2] == 2'd1) m_en = writeData[7:0];
                if (address[3:2] == 2'd3) m_ge = writeData[0];
            end
            h2 = h1; h1 = h0; h0 = irq_lines;
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int f;
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd0: return {24'h0, m_pend};
            2'd1: return {24'h0, m_en};
            2'd2: begin
                f = lowest(m_pend & m_en);
                return (f < 0) ? 32'h0 : (32'h8000_0000 | f);
            end
            default: return {31'h0, m_ge};
        endcase
    endfunction

    always @(negedge clk) begin
        check("hit", {31'h0, hit}, {31'h0, address[31:4] == BASE[31:4]});
        check("readData", readData, model_read(address));
        check("irq", {31'h0, irq}, {31'h0, m_irq});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        address = BASE | {28'h0, off, 2'b00};
        writeData = d;
        writeMem = 1'b1;
        tick();
        writeMem = 1'b0;
        writeData = 0;
        address = 0;
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] saved;
        saved = address;
        address = a;
        #1;
        check(name, readData, exp);
        address = saved;
    endtask

    task automatic claim(input logic [31:0] exp, input string name);
        address = BASE | 32'h8;
        readMem = 1'b1;
        #1;
        check(name, readData, exp);
        tick();
        readMem = 1'b0;
        address = 0;
    endtask

    localparam logic [31:0] A_PEND = BASE | 32'h0;
    localparam logic [31:0] A_EN   = BASE | 32'h4;
    localparam logic [31:0] A_CLM  = BASE | 32'h8;

    initial begin
        // reset with all lines high
        irq_lines = 8'hFF;
        repeat (3) tick();
        check("reset_irq", {31'h0, irq}, 32'h0);
        peek(A_PEND, 32'h0, "reset_pending");
        peek(A_EN, 32'h0, "reset_enable");
        peek(A_CLM, 32'h0, "reset_claim");
        rst = 1'b1;
        repeat (5) tick();
        check("post_reset_irq", {31'h0, irq}, 32'h0);
        peek(A_PEND, 32'h0000_00FF, "post_reset_pending");
        irq_lines = 8'h00;
        wr(2'd0, 32'hFF);
        repeat (3) tick();
        peek(A_PEND, 32'h0, "cleared_pending");

        // window decode
        peek(BASE | 32'h10, 32'h0, "miss_reads_zero");
        check("miss_hit", {31'h0, hit}, 32'h0);

        // edge latency on line 3
        wr(2'd1, 32'h08);
        wr(2'd3, 32'h1);
        irq_lines = 8'h08;
        tick(); check("lat_k", {31'h0, irq}, 32'h0);
        tick(); check("lat_k1", {31'h0, irq}, 32'h0);
        tick(); check("lat_k2", {31'h0, irq}, 32'h0);
        peek(A_PEND, 32'h08, "lat_pending");
        tick(); check("lat_k3", {31'h0, irq}, 32'h1);
        claim(32'h8000_0003, "claim_line3");
        peek(A_PEND, 32'h0, "after_claim3");
        check("irq_still_high", {31'h0, irq}, 32'h1);
        tick(); check("irq_falls", {31'h0, irq}, 32'h0);

        // priority between lines 2 and 5
        wr(2'd1, 32'hFF);
        irq_lines = 8'h24;
        tick();
        irq_lines = 8'h00;
        repeat (3) tick();
        peek(A_PEND, 32'h24, "prio_pending");
        peek(BASE | 32'h7, 32'hFF, "low_addr_bits_ignored");
        claim(32'h8000_0002, "claim_first");
        claim(32'h8000_0005, "claim_second");
        claim(32'h0, "claim_empty");
        check("prio_irq_low", {31'h0, irq}, 32'h0);

        // stalled claim must not clear anything
        irq_lines = 8'h12;
        tick();
        irq_lines = 8'h00;
        repeat (3) tick();
        address = A_CLM; readMem = 1'b1; stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("stall_claim_word", readData, 32'h8000_0001);
            tick();
        end
        peek(A_PEND, 32'h12, "stall_pending");
        stop = 1'b0;
        tick();
        readMem = 1'b0; address = 0;
        peek(A_PEND, 32'h10, "unstall_pending");
        claim(32'h8000_0004, "claim_line4");

        // stalled write is ignored
        stop = 1'b1;
        wr(2'd1, 32'h00);
        stop = 1'b0;
        peek(A_EN, 32'hFF, "stalled_write");

        // level line 0
        irq_lines = 8'h01;
        repeat (3) tick();
        peek(A_PEND, 32'h01, "level_set");
        wr(2'd0, 32'h01);
        peek(A_PEND, 32'h01, "level_w1c");
        claim(32'h8000_0000, "level_claim");
        peek(A_PEND, 32'h01, "level_after_claim");
        irq_lines = 8'h00;
        tick();
        peek(A_PEND, 32'h01, "level_drop_k");
        tick(); tick();
        peek(A_PEND, 32'h00, "level_drop_k2");

        // W1C collides with set of line 6
        irq_lines = 8'h40;
        tick(); tick();
        wr(2'd0, 32'h40);
        peek(A_PEND, 32'h40, "collision_pending");
        tick();
        check("collision_irq", {31'h0, irq}, 32'h1);
        claim(32'h8000_0006, "claim_line6");
        irq_lines = 8'h00;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
